// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory port, redirect input and the decode
// handshake. The master side is the fetch stage; the slave side is the
// imem/branch/decode environment around it.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [63:0]   imem_addr;
  logic [31:0]   imem_inst;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_pc;
  logic [31:0]   out_inst;
  logic [CW-1:0] count;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_inst,
    output count
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_inst,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage. Owns the PC, drives a combinational imem and
// buffers {pc, inst} pairs in a DEPTH-entry FIFO drained by decode. A redirect
// flushes the FIFO and restarts fetch at the word-aligned target.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [63:0]   r_pc;
  logic [63:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic [63:0]   w_target;
  logic          w_unused;

  // Low two target bits are dropped: fetch is always word aligned.
  assign w_target = {bus.redirect_pc[63:2], 2'b00};
  assign w_unused = ^bus.redirect_pc[1:0];

  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign w_pop  = (r_count != '0) & bus.out_ready;
  assign w_push = ~bus.redirect_valid & ((r_count < FULL) | w_pop);

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_count != '0);
  assign bus.out_pc    = r_pc_mem[r_rptr];
  assign bus.out_inst  = r_inst_mem[r_rptr];
  assign bus.count     = r_count;

  // PC: redirect wins, otherwise advance by one word on every push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_pc <= RESET_PC;
    else if (bus.redirect_valid) r_pc <= w_target;
    else if (w_push)             r_pc <= r_pc + 64'd4;
  end

  // Storage: written at the write pointer on push; cleared on reset so the
  // head outputs read as zero while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wptr]   <= r_pc;
      r_inst_mem[r_wptr] <= bus.imem_inst;
    end
  end

  // Pointers and occupancy; redirect discards everything including a
  // concurrent pop. Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop & ~w_push) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue-based reference model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [63:0] RPC = 64'h0;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Instruction memory: content is a simple function of the address.
  function automatic logic [31:0] imem(input logic [63:0] a);
    return 32'h00A00093 + a[31:0];
  endfunction
  assign bus.imem_inst = imem(bus.imem_addr);

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a queue of fetched pairs and a free-running PC.
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc = RPC;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_pc = RPC;
    end else if (bus.redirect_valid) begin
      mq.delete();
      m_pc = {bus.redirect_pc[63:2], 2'b00};
    end else begin
      if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back('{pc: m_pc, inst: imem(m_pc)});
        m_pc = m_pc + 64'd4;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model count", 64'(bus.count), 64'(mq.size()));
    chk("model out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    chk("model imem_addr", bus.imem_addr, m_pc);
    if (mq.size() != 0) begin
      chk("model out_pc", bus.out_pc, mq[0].pc);
      chk("model out_inst", 64'(bus.out_inst), 64'(mq[0].inst));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted a few time units after an edge, held through one edge.
  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst count", 64'(bus.count), 64'd0);
    chk("rst imem_addr", bus.imem_addr, RPC);
    @(posedge clk);
    #2;
    bus.out_ready = rdy;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;

    // Reset state and streaming at one instruction per cycle.
    #1;
    do_reset(1'b1);
    chk("rst out_pc", bus.out_pc, 64'h0);
    chk("stream pc0", bus.out_pc, 64'h0);
    chk("stream inst0", 64'(bus.out_inst), 64'h00A00093);
    chk("stream cnt", 64'(bus.count), 64'd1);
    step();
    chk("stream pc1", bus.out_pc, 64'h4);
    chk("stream inst1", 64'(bus.out_inst), 64'h00A00097);
    step();
    chk("stream pc2", bus.out_pc, 64'h8);
    chk("stream cnt2", 64'(bus.count), 64'd1);

    // Backpressure from reset: fills in DEPTH edges, then holds.
    #2;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("full count", 64'(bus.count), 64'd4);
    chk("full imem_addr", bus.imem_addr, 64'h10);
    chk("full out_pc", bus.out_pc, 64'h0);

    // One-cycle pop while full: slot reused, PC 16 enqueued.
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("popfull count", 64'(bus.count), 64'd4);
    chk("popfull head", bus.out_pc, 64'h4);
    chk("popfull imem_addr", bus.imem_addr, 64'h14);
    step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain head", bus.out_pc, 64'h8 + 64'(4 * i));
    end

    // Redirect at count 3 with a concurrent pop.
    #2;
    do_reset(1'b0);
    step();
    step();
    chk("pre-redir count", 64'(bus.count), 64'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h200;
    bus.out_ready      = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    chk("redir count", 64'(bus.count), 64'd0);
    chk("redir out_valid", 64'(bus.out_valid), 64'd0);
    chk("redir imem_addr", bus.imem_addr, 64'h200);
    step();
    chk("redir head", bus.out_pc, 64'h200);
    chk("redir inst", 64'(bus.out_inst), 64'h00A00293);

    // Held redirect keeps the queue empty.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h300;
    step();
    step();
    chk("held redir count", 64'(bus.count), 64'd0);

    // Misaligned target and PC wrap past 2^64.
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    bus.redirect_valid = 1'b0;
    chk("wrap imem_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap head0", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap inst0", 64'(bus.out_inst), 64'h00A0008F);
    step();
    chk("wrap head1", bus.out_pc, 64'h0);
    step();
    chk("wrap head2", bus.out_pc, 64'h4);

    // Asynchronous reset mid-operation at count 2.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1000;
    bus.out_ready      = 1'b0;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    chk("mid count", 64'(bus.count), 64'd2);
    #1;
    do_reset(1'b1);
    chk("restart head0", bus.out_pc, RPC);
    step();
    chk("restart head1", bus.out_pc, RPC + 64'd4);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
